pipe_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipelined MIPS core. Watches the IF/ID, ID/EX and EX/MEM pipeline-register outputs and the data-memory ready handshake. Drives write-enables, bubble and flush controls for the pipeline registers and the PC source select. Its state is updated on posedge CLK so that control outputs are stable before the pipeline registers latch on negedge CLK.

---
 rtl/pipe_hazard_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage MIPS pipeline. It updates on posedge CLK,
// so the control outputs are stable before the pipeline registers latch on negedge CLK.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             id_ex_MemRead,
  input  logic [4:0]       id_ex_Wreg_addr,
  input  logic             ex_mem_PCSrc,
  input  logic             ex_mem_JtoPC,
  input  logic             ex_mem_MemRead,
  input  logic             ex_mem_MemWrite,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             idex_bubble,
  output logic             memwb_bubble,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state
);

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int FLUSH_W = 4;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_STALL_LU = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_FLUSH    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic               pc_write_q, pc_write_d;
  logic [1:0]         pc_sel_q, pc_sel_d;
  logic               ifid_write_q, ifid_write_d;
  logic               idex_write_q, idex_write_d;
  logic               exmem_write_q, exmem_write_d;
  logic               idex_bubble_q, idex_bubble_d;
  logic               memwb_bubble_q, memwb_bubble_d;
  logic               flush_ifid_q, flush_ifid_d;
  logic               flush_idex_q, flush_idex_d;

  logic mem_hz, redir, lu_hz;

  assign mem_hz = (ex_mem_MemRead | ex_mem_MemWrite) & ~dmem_ready;
  assign redir  = ex_mem_PCSrc | ex_mem_JtoPC;
  assign lu_hz  = id_ex_MemRead && (id_ex_Wreg_addr != 5'd0) &&
                  ((use_rs && (id_ex_Wreg_addr == if_id_rs)) ||
                   (use_rt && (id_ex_Wreg_addr == if_id_rt)));

  // Next-state logic; outputs are decoded from the next state so they can be registered.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    state_d   = state_q;
    wait_d    = wait_q;
    flush_d   = flush_q;
    mem_err_d = mem_err_q;

    unique case (state_q)
      S_RUN, S_STALL_LU: begin
        if (mem_hz) begin
          state_d = S_MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else if (redir) begin
          state_d = S_FLUSH;
          flush_d = FLUSH_W'(1);
        end else if (lu_hz && state_q == S_RUN) begin
          state_d = S_STALL_LU;
        end else begin
          state_d = S_RUN;
        end
      end
      S_MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = S_RUN;
        end else if (wait_q >= WAIT_W'(MEM_TIMEOUT)) begin
          state_d   = S_RUN;
          mem_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_FLUSH: begin
        if (mem_hz) begin
          state_d = S_MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else if (flush_q >= FLUSH_W'(FLUSH_CYCLES)) begin
          state_d = S_RUN;
        end else begin
          flush_d = flush_q + FLUSH_W'(1);
        end
      end
      default: state_d = S_RUN;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (state_d != S_RUN && stall_cnt_q != {CNT_W{1'b1}})
      stall_cnt_d = stall_cnt_q + CNT_W'(1);

    pc_write_d     = 1'b1;
    pc_sel_d       = 2'd0;
    ifid_write_d   = 1'b1;
    idex_write_d   = 1'b1;
    exmem_write_d  = 1'b1;
    idex_bubble_d  = 1'b0;
    memwb_bubble_d = 1'b0;
    flush_ifid_d   = 1'b0;
    flush_idex_d   = 1'b0;

    unique case (state_d)
      S_STALL_LU: begin
        pc_write_d    = 1'b0;
        ifid_write_d  = 1'b0;
        idex_bubble_d = 1'b1;
      end
      S_MEM_WAIT: begin
        pc_write_d     = 1'b0;
        ifid_write_d   = 1'b0;
        idex_write_d   = 1'b0;
        exmem_write_d  = 1'b0;
        memwb_bubble_d = 1'b1;
      end
      S_FLUSH: begin
        flush_ifid_d = 1'b1;
        flush_idex_d = 1'b1;
        // Redirect target is only presented on the first flush cycle; jump beats branch.
        if (state_q != S_FLUSH)
          pc_sel_d = ex_mem_JtoPC ? 2'd2 : 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= S_RUN;
      wait_q         <= '0;
      flush_q        <= '0;
      mem_err_q      <= 1'b0;
      stall_cnt_q    <= '0;
      pc_write_q     <= 1'b1;
      pc_sel_q       <= 2'd0;
      ifid_write_q   <= 1'b1;
      idex_write_q   <= 1'b1;
      exmem_write_q  <= 1'b1;
      idex_bubble_q  <= 1'b0;
      memwb_bubble_q <= 1'b0;
      flush_ifid_q   <= 1'b0;
      flush_idex_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q        <= state_d;
      wait_q         <= wait_d;
      flush_q        <= flush_d;
      mem_err_q      <= mem_err_d;
      stall_cnt_q    <= stall_cnt_d;
      pc_write_q     <= pc_write_d;
      pc_sel_q       <= pc_sel_d;
      ifid_write_q   <= ifid_write_d;
      idex_write_q   <= idex_write_d;
      exmem_write_q  <= exmem_write_d;
      idex_bubble_q  <= idex_bubble_d;
      memwb_bubble_q <= memwb_bubble_d;
      flush_ifid_q   <= flush_ifid_d;
      flush_idex_q   <= flush_idex_d;
    end
  end

  assign pc_write     = pc_write_q;
  assign pc_sel       = pc_sel_q;
  assign ifid_write   = ifid_write_q;
  assign idex_write   = idex_write_q;
  assign exmem_write  = exmem_write_q;
  assign idex_bubble  = idex_bubble_q;
  assign memwb_bubble = memwb_bubble_q;
  assign flush_ifid   = flush_ifid_q;
  assign flush_idex   = flush_idex_q;
  assign mem_err      = mem_err_q;
  assign stall_cnt    = stall_cnt_q;
  assign state        = state_q;

endmodule
